// File: rtl/pipe_pkg.sv
// Shared types, opcode field constants and the forwarding-select helper for
// the pipeline sequencer (pipe_ctrl) and its instruction decoder.
package pipe_pkg;

  localparam logic [15:0] NOP_WORD_DEFAULT = 16'h8100;

  // Opcode field patterns
  localparam logic [1:0] LD_HI      = 2'b00;    // [15:14]
  localparam logic [7:0] LD_LO      = 8'h01;    // [7:0]
  localparam logic [4:0] ST_HI      = 5'b00000; // [15:11]
  localparam logic [4:0] ST_LO      = 5'b00000; // [4:0]
  localparam logic [7:0] BR_OP      = 8'h80;    // [15:8]
  localparam logic [4:0] BZ_OP      = 5'b10001; // [15:11]
  localparam logic [4:0] BNZ_OP     = 5'b10010; // [15:11]
  localparam logic [1:0] ALU_HI     = 2'b00;    // [15:14]
  localparam logic [4:0] ALU_LO_A   = 5'b00010; // [4:0]
  localparam logic [4:0] ALU_LO_B   = 5'b00100;
  localparam logic [4:0] ALU_LO_C   = 5'b00101;
  localparam logic [1:0] WR_HI_ALL  = 2'b11;    // [15:14], always writes
  localparam logic [1:0] WR_HI_COND = 2'b01;    // [15:14], writes when [10:8]=0

  localparam logic [3:0] PH_FIRST = 4'b0001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_EX = 2'b01,
    FWD_WB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic       is_ld;
    logic       is_st;
    logic       is_br;
    logic       writes_reg;
    logic       reads_src2;
    logic [2:0] dest;
    logic [2:0] src1;
    logic [2:0] src2;
  } insn_t;

  // Execute-stage result wins over writeback; loads in execute have no
  // result yet and are handled by the stall instead.
  function automatic fwd_sel_t fwd_pick(input logic [2:0] src,
                                        input insn_t      e,
                                        input insn_t      w);
    if (e.writes_reg && !e.is_ld && (e.dest == src)) return FWD_EX;
    if (w.writes_reg && (w.dest == src))              return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/insn_decode.sv
// Combinational class decode of one 16-bit instruction word; the bubble
// word NOP_WORD is forced out of every class.
module insn_decode
  import pipe_pkg::*;
#(
  parameter logic [15:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic [15:0] word,
  output insn_t       info
);

  logic is_nop;

  always_comb begin
    // NOTE: every field gets a default first so no path can infer a latch.
    info   = '0;
    is_nop = (word == NOP_WORD);

    info.dest = word[13:11];
    info.src1 = word[10:8];
    info.src2 = word[7:5];

    if (!is_nop) begin
      info.is_ld = (word[15:14] == LD_HI) && (word[7:0] == LD_LO);
      info.is_st = (word[15:11] == ST_HI) && (word[4:0] == ST_LO);
      info.is_br = (word[15:8] == BR_OP) || (word[15:11] == BZ_OP) ||
                   (word[15:11] == BNZ_OP);
      info.writes_reg = info.is_ld ||
                        ((word[15:14] == ALU_HI) &&
                         ((word[4:0] == ALU_LO_A) || (word[4:0] == ALU_LO_B) ||
                          (word[4:0] == ALU_LO_C))) ||
                        (word[15:14] == WR_HI_ALL) ||
                        ((word[15:14] == WR_HI_COND) && (word[10:8] == 3'b000));
    end

    // Branches carry an offset in the src2 field, not a register number.
    info.reads_src2 = !info.is_br;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Phase-ring sequencer and hazard controller for the 3-stage core.
// Define PIPE_CTRL_FWD_EN for operand forwarding; otherwise RAW hazards stall.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter logic [15:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] ir_d,
  input  logic [15:0] ir_e,
  input  logic [15:0] ir_w,
  input  logic        br_taken,
  output logic [3:0]  ph,
  output logic        adv_if,
  output logic        adv_id,
  output logic        bubble,
  output logic        flush,
  output logic [1:0]  fwd_sr1,
  output logic [1:0]  fwd_sr2,
  output logic        busy,
  output logic [15:0] retired
);

  state_t     state;
  insn_t      dec_d, dec_e, dec_w;
  logic [1:0] stall_cnt;
  logic [1:0] stall_left;
  logic [1:0] hz_rounds;
  logic       flush_q;
  logic       e_hits;
  logic [3:0] ph_rot;
  logic       unused_fields;

  insn_decode #(.NOP_WORD(NOP_WORD)) u_dec_d (.word(ir_d), .info(dec_d));
  insn_decode #(.NOP_WORD(NOP_WORD)) u_dec_e (.word(ir_e), .info(dec_e));
  insn_decode #(.NOP_WORD(NOP_WORD)) u_dec_w (.word(ir_w), .info(dec_w));

  // Not every decoded field matters in every stage.
  assign unused_fields = ^{dec_d, dec_e, dec_w};

  assign ph_rot = {ph[2:0], ph[3]};

  assign e_hits = dec_e.writes_reg &&
                  ((dec_e.dest == dec_d.src1) ||
                   (dec_d.reads_src2 && (dec_e.dest == dec_d.src2)));

`ifdef PIPE_CTRL_FWD_EN
  // Only a load in execute cannot be forwarded; one round moves it to writeback.
  assign hz_rounds = (dec_e.is_ld && e_hits) ? 2'd1 : 2'd0;
  assign fwd_sr1   = fwd_pick(dec_d.src1, dec_e, dec_w);
  assign fwd_sr2   = fwd_pick(dec_d.src2, dec_e, dec_w);
`else
  logic w_hits;

  assign w_hits = dec_w.writes_reg &&
                  ((dec_w.dest == dec_d.src1) ||
                   (dec_d.reads_src2 && (dec_w.dest == dec_d.src2)));
  // Without forwarding the consumer waits until the producer has retired.
  assign hz_rounds = e_hits ? 2'd2 : (w_hits ? 2'd1 : 2'd0);
  assign fwd_sr1   = FWD_RF;
  assign fwd_sr2   = FWD_RF;
`endif

  assign stall_left = (stall_cnt != 2'd0) ? stall_cnt - 2'd1 : 2'd0;

  // Phase FSM: registered ring and busy.
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state <= IDLE;
      ph    <= '0;
      busy  <= 1'b0;
    end else begin
      // NOTE: state registers use <= so each sees only pre-edge values.
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= RUN;
            ph    <= PH_FIRST;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (stop && ph[3]) begin
            state <= IDLE;
            ph    <= '0;
            busy  <= 1'b0;
          end else begin
            if (stop) state <= DRAIN;
            ph <= ph_rot;
          end
        end
        DRAIN: begin
          if (start && !stop) begin
            state <= RUN;
            ph    <= ph_rot;
          end else if (ph[3]) begin
            state <= IDLE;
            ph    <= '0;
            busy  <= 1'b0;
          end else begin
            ph <= ph_rot;
          end
        end
        default: begin
          state <= IDLE;
          ph    <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Round-boundary latches and retire counter, all updated at ph[3].
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      stall_cnt <= 2'd0;
      flush_q   <= 1'b0;
      retired   <= 16'd0;
    end else if (ph[3]) begin
      if (br_taken) begin
        flush_q   <= 1'b1;
        stall_cnt <= 2'd0;
      end else begin
        flush_q   <= 1'b0;
        stall_cnt <= (stall_left > hz_rounds) ? stall_left : hz_rounds;
      end
      if (ir_w != NOP_WORD) retired <= retired + 16'd1;
    end
  end

  assign flush  = flush_q;
  assign bubble = !flush_q && (stall_cnt != 2'd0);
  assign adv_if = flush_q || (stall_cnt == 2'd0);
  assign adv_id = 1'b1;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; expectations are hand-derived
// and follow PIPE_CTRL_FWD_EN when it is defined.
module tb_pipe_ctrl;

  localparam logic [15:0] NOP       = 16'h8100;
  localparam logic [15:0] LD_R3     = 16'h1801; // ld r3
  localparam logic [15:0] USE_R3    = 16'h0304; // alu, src1=r3
  localparam logic [15:0] ALU_R2    = 16'h1004; // alu, dest=r2
  localparam logic [15:0] ALU2_R2   = 16'h1005; // alu, dest=r2
  localparam logic [15:0] USE_R2_S1 = 16'h0204; // alu, src1=r2
  localparam logic [15:0] USE_R2_S2 = 16'h0044; // alu, src2=r2

  logic        CLK = 1'b0;
  logic        RSTN, start, stop, br_taken;
  logic [15:0] ir_d, ir_e, ir_w;
  logic [3:0]  ph;
  logic        adv_if, adv_id, bubble, flush, busy;
  logic [1:0]  fwd_sr1, fwd_sr2;
  logic [15:0] retired;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ret  = 0;

  pipe_ctrl dut (
    .CLK(CLK), .RSTN(RSTN), .start(start), .stop(stop),
    .ir_d(ir_d), .ir_e(ir_e), .ir_w(ir_w), .br_taken(br_taken),
    .ph(ph), .adv_if(adv_if), .adv_id(adv_id), .bubble(bubble),
    .flush(flush), .fwd_sr1(fwd_sr1), .fwd_sr2(fwd_sr2),
    .busy(busy), .retired(retired)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full round from ph=0001 to the next ph=0001.
  task automatic run_round();
    bit ret;
    ret = (ir_w !== NOP);
    repeat (4) tick();
    if (ret) exp_ret++;
  endtask

  initial begin
    RSTN = 1'b1; start = 1'b0; stop = 1'b0; br_taken = 1'b0;
    ir_d = NOP; ir_e = NOP; ir_w = NOP;

    // Reset state
    tick(); tick();
    check("rst_ph", ph, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_retired", retired, 16'd0);
    check("rst_adv_if", adv_if, 1'b1);
    check("rst_adv_id", adv_id, 1'b1);
    check("rst_bubble", bubble, 1'b0);
    check("rst_flush", flush, 1'b0);
    check("rst_fwd_sr1", fwd_sr1, 2'b00);
    check("rst_fwd_sr2", fwd_sr2, 2'b00);
    RSTN = 1'b0;
    tick();
    check("idle_ph", ph, 4'b0000);

    // Start and ring rotation
    start = 1'b1;
    #1 check("pre_start_ph", ph, 4'b0000);
    tick();
    check("start_ph0", ph, 4'b0001);
    check("start_busy", busy, 1'b1);
    start = 1'b0;
    tick(); check("ring_ph1", ph, 4'b0010);
    tick(); check("ring_ph2", ph, 4'b0100);
    tick(); check("ring_ph3", ph, 4'b1000);
    tick(); check("ring_wrap", ph, 4'b0001);
    check("ret_nop", retired, 16'd0);

    // Load-use hazard
    ir_e = LD_R3; ir_d = USE_R3;
    #1 check("lu_fwd_pre", fwd_sr1, 2'b00);
    run_round();
    check("lu_align", ph, 4'b0001);
    check("lu_adv_if", adv_if, 1'b0);
    check("lu_bubble", bubble, 1'b1);
    check("lu_adv_id", adv_id, 1'b1);
    check("lu_flush", flush, 1'b0);
    ir_e = NOP; ir_w = LD_R3;
`ifdef PIPE_CTRL_FWD_EN
    #1 check("lu_fwd_wb", fwd_sr1, 2'b10);
    run_round();
    check("lu_after_adv_if", adv_if, 1'b1);
    check("lu_after_bubble", bubble, 1'b0);
    check("lu_after_fwd", fwd_sr1, 2'b10);
    ir_w = NOP;
`else
    #1 check("lu_fwd_tied", fwd_sr1, 2'b00);
    run_round();
    check("lu_stall2_adv_if", adv_if, 1'b0);
    check("lu_stall2_bubble", bubble, 1'b1);
    ir_w = NOP;
    run_round();
    check("lu_after_adv_if", adv_if, 1'b1);
    check("lu_after_bubble", bubble, 1'b0);
`endif
    check("ret_after_lu", retired, 16'(exp_ret));

    // Forwarding priority / RAW without forwarding
`ifdef PIPE_CTRL_FWD_EN
    ir_d = USE_R2_S1; ir_e = ALU_R2; ir_w = NOP;
    #1 check("fwd_ex_sr1", fwd_sr1, 2'b01);
    check("fwd_ex_sr2", fwd_sr2, 2'b00);
    ir_w = ALU2_R2;
    #1 check("fwd_prio_sr1", fwd_sr1, 2'b01);
    ir_e = NOP;
    #1 check("fwd_wb_sr1", fwd_sr1, 2'b10);
    ir_d = USE_R2_S2; ir_e = ALU_R2; ir_w = NOP;
    #1 check("fwd_ex_sr2b", fwd_sr2, 2'b01);
    check("fwd_rf_sr1b", fwd_sr1, 2'b00);
    run_round();
    check("fwd_nostall_adv_if", adv_if, 1'b1);
    check("fwd_nostall_bubble", bubble, 1'b0);
`else
    ir_d = USE_R2_S1; ir_e = ALU_R2; ir_w = NOP;
    #1 check("raw_fwd_sr1", fwd_sr1, 2'b00);
    check("raw_fwd_sr2", fwd_sr2, 2'b00);
    run_round();
    check("raw_r1_adv_if", adv_if, 1'b0);
    check("raw_r1_bubble", bubble, 1'b1);
    ir_e = NOP; ir_w = ALU_R2;
    run_round();
    check("raw_r2_adv_if", adv_if, 1'b0);
    check("raw_r2_bubble", bubble, 1'b1);
    ir_w = NOP;
    run_round();
    check("raw_done_adv_if", adv_if, 1'b1);
    check("raw_done_bubble", bubble, 1'b0);
`endif
    ir_d = NOP; ir_e = NOP; ir_w = NOP;
    check("ret_after_fwd", retired, 16'(exp_ret));

    // Branch flush over a pending load-use stall
    ir_d = USE_R3; ir_e = LD_R3; br_taken = 1'b1;
    run_round();
    check("br_flush", flush, 1'b1);
    check("br_bubble", bubble, 1'b0);
    check("br_adv_if", adv_if, 1'b1);
    check("br_adv_id", adv_id, 1'b1);
    br_taken = 1'b0; ir_d = NOP; ir_e = NOP;
    run_round();
    check("br_clr_flush", flush, 1'b0);
    check("br_clr_bubble", bubble, 1'b0);
    check("br_clr_adv_if", adv_if, 1'b1);

    // Stop at ph[1]
    tick();
    check("stop_at_ph1", ph, 4'b0010);
    stop = 1'b1;
    tick(); check("drain_ph2", ph, 4'b0100);
    check("drain_busy", busy, 1'b1);
    tick(); check("drain_ph3", ph, 4'b1000);
    tick(); check("stop_idle_ph", ph, 4'b0000);
    check("stop_idle_busy", busy, 1'b0);
    start = 1'b1;
    tick(); check("both_idle_ph", ph, 4'b0000);
    check("both_idle_busy", busy, 1'b0);
    stop = 1'b0;
    tick(); check("restart_ph", ph, 4'b0001);
    start = 1'b0;

    // Reset mid-round at ph[2]
    ir_w = ALU_R2;
    tick(); tick();
    check("pre_rst_ph", ph, 4'b0100);
    RSTN = 1'b1;
    tick();
    check("midrst_ph", ph, 4'b0000);
    check("midrst_retired", retired, 16'd0);
    check("midrst_busy", busy, 1'b0);
    RSTN = 1'b0; ir_w = NOP;

    // Retire counter wrap
    start = 1'b1;
    tick(); start = 1'b0;
    check("wrap_start_ph", ph, 4'b0001);
    force dut.retired = 16'hFFFF;
    #1 release dut.retired;
    ir_w = ALU_R2;
    run_round();
    check("ret_wrap", retired, 16'h0000);
    run_round();
    check("ret_after_wrap", retired, 16'h0001);
    ir_w = NOP;
    run_round();
    check("ret_nop_hold", retired, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencer and hazard controller for the 3-stage phased CPU core. It replaces the free-running phase machine and the ad-hoc forwarding compares. It generates the one-hot phase ring, gates the fetch/decode loads, inserts bubbles on load-use hazards, and flushes the two younger stages on a taken branch. It also drives operand-forwarding selects and counts retired instructions. It sits between the start/stop buttons and the pc/ir/ir1/ir2 register chain.

## Interface
- `NOP_WORD`, default 16'h8100: bubble instruction word; writes no register, no memory, no pc.
- `CLK` in 1: single clock.
- `RSTN` in 1: synchronous reset, **active-high**, sampled on the `CLK` rising edge.
- `start` in 1: level; begin running.
- `stop` in 1: level; halt at the end of the current round.
- `ir_d` in 16: decode-stage word (ir).
- `ir_e` in 16: execute-stage word (ir1).
- `ir_w` in 16: writeback-stage word (ir2).
- `br_taken` in 1: taken branch in writeback; valid during `ph[3]`.
- `ph` out 4: one-hot phase; 4'b0000 when idle.
- `adv_if` out 1: enables pc increment and ir load; used qualified with `ph[0]`.
- `adv_id` out 1: enables the ir1/pc1 load; used qualified with `ph[1]`.
- `bubble` out 1: ir1 loads `NOP_WORD` instead of ir.
- `flush` out 1: ir and ir1 load `NOP_WORD`.
- `fwd_sr1` out 2: sr1 source; 00 = regfile, 01 = execute result, 10 = writeback data.
- `fwd_sr2` out 2: sr2 source; same encoding as `fwd_sr1`.
- `busy` out 1: high in RUN or DRAIN.
- `retired` out 16: count of non-NOP instructions completed in writeback.

## Operation
- **FSM states:**
  - IDLE: `ph` = 0.
  - RUN: `ph` rotates 0001→0010→0100→1000→0001, one step per clock.
  - DRAIN: the ring continues to `ph[3]`, then the FSM enters IDLE.
- **FSM transitions:**
  - IDLE→RUN on `start`. The first `ph` = 0001 appears on the next clock.
  - RUN→DRAIN on `stop`.
  - DRAIN→RUN on `start` with `stop` low.
  - `start` and `stop` high together: `stop` wins.
  - `start` while in RUN is ignored.
- **Decode classes** (dest = [13:11], src1 = [10:8], src2 = [7:5]):
  - LD: [15:14]=00, [7:0]=01.
  - ST: [15:11]=00000, [4:0]=0.
  - Branch: [15:8]=0x80, or [15:11]=10001, or [15:11]=10010.
  - Register-writers: LD; [15:14]=00 with [4:0] ∈ {00010, 00100, 00101}; [15:14]=11; [15:14]=01 with [10:8]=000.
  - `NOP_WORD` belongs to no class.
- **Load-use hazard:** `ir_e` is LD, and its dest equals a source of `ir_d` that `ir_d` reads (src1 always; src2 for non-branch).
  - The hazard is latched at `ph[3]` into a 1-round stall.
  - During the stalled round: `adv_if` = 0, `adv_id` = 1, `bubble` = 1.
  - Only one stall per hazard. The re-evaluation after the stall sees LD in writeback, so forwarding covers it.
- **Branch flush:** `br_taken` at `ph[3]` sets `flush` for the whole next round.
  - Flush overrides stall: the stall is cleared and `bubble` is ignored.
  - `adv_if` stays 1 so the new pc fetches.
- **Forwarding (combinational from `ir_d`, `ir_e`, `ir_w`):**
  - 01 when `ir_e` is a non-LD register-writer with dest equal to the source.
  - 10 when `ir_w` is a register-writer with dest equal to the source.
  - Execute (01) has priority over writeback (10).
- **Retire counter:** `retired` increments at `ph[3]` when `ir_w` ≠ `NOP_WORD`. It wraps 16'hFFFF→0.
- **Reset:** FSM IDLE; `ph` = 0; `adv_if` = 1; `adv_id` = 1; `bubble`, `flush`, `busy` = 0; `fwd_*` = 00; `retired` = 0; stall and flush latches cleared. Reset mid-round takes effect immediately and wins over all inputs.

## Timing
- `ph`, `busy`, `retired`, the stall latch and the flush latch are registered.
- `adv_if`, `adv_id`, `bubble` and `flush` are decoded from the latches. They are stable for a whole round.
- `fwd_*` is combinational. The datapath samples it at `ph[1]` (sr1/sr2 load).
- Hazard/branch at `ph[3]` of round N → action through round N+1 → cleared at `ph[3]` of round N+1, unless re-triggered.
- `start` → `ph` = 0001: 1 clock.
- `stop` asserted at `ph[k]` → IDLE after 4−k clocks (at `ph[3]`: 1 clock).

## Configuration
- `PIPE_CTRL_FWD_EN` defined: forwarding as specified above.
- Undefined:
  - `fwd_sr1` and `fwd_sr2` are tied 00.
  - Any source match against an `ir_e` register-writer stalls 2 rounds.
  - Any source match against an `ir_w` register-writer stalls 1 round.
  - Stalls use the same `adv_if`/`bubble` behaviour as the load-use stall.
  - `flush` still overrides.

## Structure
- Package `pipe_pkg`:
  - `NOP_WORD` default.
  - Opcode field constants (LD, ST, B/BZ/BNZ patterns).
  - FSM state enum {IDLE, RUN, DRAIN}.
  - `fwd_sel` enum.
- Sub-module `insn_decode` (combinational): from one word produce `is_ld`, `is_st`, `is_br`, `writes_reg`, `reads_src2`, `dest`, `src1`, `src2`. Instantiate it three times (d/e/w).

## Test plan
- **Reset/start:** RSTN=1 for 2 clocks, then `start` pulse → `ph` = 0000 until the clock after `start`, then 0001, 0010, 0100, 1000, 0001; `busy`=1.
- **Load-use:** `ir_e` = LD r3 (0x1801), `ir_d` reads r3 in src1 (0x0304) → next round `adv_if`=0, `bubble`=1; the following round `adv_if`=1 and `fwd_sr1`=10.
- **Forward priority:** `ir_e` and `ir_w` both write r2 (both ALU ops), `ir_d` src1=r2 → `fwd_sr1`=01. With `ir_e`=`NOP_WORD` → 10.
- **Branch flush:** `br_taken`=1 at `ph[3]` together with a pending load-use → next round `flush`=1, `bubble`=0, `adv_if`=1; the round after, all clear.
- **Stop/start:** `stop` at `ph[1]` → `ph[3]` then IDLE 2 clocks later. `start` and `stop` together in IDLE → remains IDLE. Reset asserted at `ph[2]` → `ph`=0 and `retired`=0 next clock.
- **Retire wrap:** preload via 65535 retirements, or force; one more non-NOP at `ph[3]` → `retired`=0. With `PIPE_CTRL_FWD_EN` undefined, the ALU-writer RAW case gives a 2-round stall and `fwd`=00.
